alu_issue_stage: RTL and testbench

//   ID/EX issue register in front of the 64-bit ALU. Each cycle it captures one

---
 rtl/alu_issue_stage.sv | 120 ++++++++++++
 tb/tb_alu_issue_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the 64-bit ALU: decodes the ALU op, resolves
// forwarding and selects operands, and handles stall, flush and bubbles.
module alu_issue_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        aluop,
    input  logic              is_rtype,
    input  logic [2:0]        funct3,
    input  logic              funct7_b5,
    input  logic              alu_src,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   imm,
    input  logic              fwdA_we,
    input  logic [REG_AW-1:0] fwdA_rd,
    input  logic [XLEN-1:0]   fwdA_data,
    input  logic              fwdB_we,
    input  logic [REG_AW-1:0] fwdB_rd,
    input  logic [XLEN-1:0]   fwdB_data,
    input  logic              stall,
    input  logic              flush,
    output logic [XLEN-1:0]   alu_rs1,
    output logic [XLEN-1:0]   alu_rs2,
    output logic [3:0]        alu_code,
    output logic [REG_AW-1:0] rd_out,
    output logic              out_valid,
    output logic              illegal_op
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_ILL = 4'b1111;

    logic [3:0]      code_d;
    logic            ill_d;
    logic [XLEN-1:0] op1_d;
    logic [XLEN-1:0] fwd2_d;
    logic [XLEN-1:0] op2_d;

    assign in_ready = ~stall;

    always_comb begin
        code_d = OP_ADD;
        ill_d  = 1'b0;
        unique case (1'b1)
            aluop == 2'b00: code_d = OP_ADD;
            aluop == 2'b01: code_d = OP_SUB;
            aluop == 2'b11: begin
                code_d = OP_ILL;
                ill_d  = 1'b1;
            end
            default: begin
                unique case (1'b1)
                    funct3 == 3'b000:
                        code_d = (is_rtype & funct7_b5) ? OP_SUB : OP_ADD;
                    funct3 == 3'b111: code_d = OP_AND;
                    funct3 == 3'b110: code_d = OP_OR;
                    default: begin
                        code_d = OP_ILL;
                        ill_d  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Newer result (A) beats older (B); x0 never forwards and reads zero.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   rf
    );
        logic [XLEN-1:0] v;
        v = rf;
        if (addr == '0)
            v = '0;
        else if (fwdA_we && fwdA_rd == addr)
            v = fwdA_data;
        else if (fwdB_we && fwdB_rd == addr)
            v = fwdB_data;
        return v;
    endfunction

    always_comb begin
        op1_d  = fwd_sel(rs1_addr, rs1_data);
        fwd2_d = fwd_sel(rs2_addr, rs2_data);
        op2_d  = alu_src ? imm : fwd2_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_rs1    <= '0;
            alu_rs2    <= '0;
            alu_code   <= OP_AND;
            rd_out     <= '0;
            out_valid  <= 1'b0;
            illegal_op <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            illegal_op <= 1'b0;
        end else if (!stall) begin
            alu_rs1    <= op1_d;
            alu_rs2    <= op2_d;
            alu_code   <= code_d;
            rd_out     <= rd_addr;
            out_valid  <= in_valid;
            illegal_op <= in_valid & ill_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomized checks of alu_issue_stage against a
// behavioural model of the issue register.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready;
    logic [1:0]  aluop;
    logic        is_rtype, funct7_b5, alu_src;
    logic [2:0]  funct3;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [63:0] rs1_data, rs2_data, imm;
    logic        fwdA_we, fwdB_we;
    logic [4:0]  fwdA_rd, fwdB_rd;
    logic [63:0] fwdA_data, fwdB_data;
    logic        stall, flush;
    logic [63:0] alu_rs1, alu_rs2;
    logic [3:0]  alu_code;
    logic [4:0]  rd_out;
    logic        out_valid, illegal_op;

    int errors = 0;
    int checks = 0;

    logic [63:0] e_rs1, e_rs2;
    logic [3:0]  e_code;
    logic [4:0]  e_rd;
    logic        e_valid, e_ill;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .is_rtype(is_rtype),
        .funct3(funct3), .funct7_b5(funct7_b5),
        .alu_src(alu_src),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm),
        .fwdA_we(fwdA_we), .fwdA_rd(fwdA_rd),
        .fwdA_data(fwdA_data),
        .fwdB_we(fwdB_we), .fwdB_rd(fwdB_rd),
        .fwdB_data(fwdB_data),
        .stall(stall), .flush(flush),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_code(alu_code), .rd_out(rd_out),
        .out_valid(out_valid), .illegal_op(illegal_op)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_src(input logic [4:0] a,
                                          input logic [63:0] rf);
        if (a == 0) return 64'd0;
        if (fwdA_we && fwdA_rd == a) return fwdA_data;
        if (fwdB_we && fwdB_rd == a) return fwdB_data;
        return rf;
    endfunction

    // Returns {illegal, code} for the current decode inputs.
    function automatic logic [4:0] m_op();
        if (aluop == 2'd0) return 5'h02;
        if (aluop == 2'd1) return 5'h03;
        if (aluop == 2'd3) return 5'h1F;
        if (funct3 == 3'd0)
            return (is_rtype && funct7_b5) ? 5'h03 : 5'h02;
        if (funct3 == 3'd7) return 5'h00;
        if (funct3 == 3'd6) return 5'h01;
        return 5'h1F;
    endfunction

    task automatic model_edge();
        logic [4:0] op;
        op = m_op();
        if (flush) begin
            e_valid = 0;
            e_ill = 0;
        end else if (!stall) begin
            e_rs1 = m_src(rs1_addr, rs1_data);
            e_rs2 = alu_src ? imm : m_src(rs2_addr, rs2_data);
            e_code = op[3:0];
            e_rd = rd_addr;
            e_valid = in_valid;
            e_ill = in_valid && op[4];
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'(e_valid));
        chk({tag, ".ill"}, 64'(illegal_op), 64'(e_ill));
        chk({tag, ".ready"}, 64'(in_ready), 64'(!stall));
        if (e_valid) begin
            chk({tag, ".rs1"}, alu_rs1, e_rs1);
            chk({tag, ".rs2"}, alu_rs2, e_rs2);
            chk({tag, ".code"}, 64'(alu_code), 64'(e_code));
            chk({tag, ".rd"}, 64'(rd_out), 64'(e_rd));
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        in_valid = 0; aluop = 0; is_rtype = 0;
        funct3 = 0; funct7_b5 = 0; alu_src = 0;
        rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
        rs1_data = 0; rs2_data = 0; imm = 0;
        fwdA_we = 0; fwdA_rd = 0; fwdA_data = 0;
        fwdB_we = 0; fwdB_rd = 0; fwdB_data = 0;
        stall = 0; flush = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rs1"}, alu_rs1, 64'd0);
        chk({tag, ".rs2"}, alu_rs2, 64'd0);
        chk({tag, ".code"}, 64'(alu_code), 64'd0);
        chk({tag, ".rd"}, 64'(rd_out), 64'd0);
        chk({tag, ".valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".ill"}, 64'(illegal_op), 64'd0);
        e_rs1 = 0; e_rs2 = 0; e_code = 0;
        e_rd = 0; e_valid = 0; e_ill = 0;
    endtask

    logic [63:0] frz1, frz2;

    initial begin
        idle();
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1;

        // R-type subtract
        in_valid = 1; aluop = 2; funct3 = 0;
        funct7_b5 = 1; is_rtype = 1;
        rs1_addr = 1; rs2_addr = 2; rd_addr = 9;
        rs1_data = 5; rs2_data = 3;
        step("rsub");
        chk("rsub.code_abs", 64'(alu_code), 64'h3);
        chk("rsub.op1_abs", alu_rs1, 64'd5);
        chk("rsub.op2_abs", alu_rs2, 64'd3);

        // Forward priority, then x0
        rs1_addr = 7; rs1_data = 64'h11;
        fwdA_we = 1; fwdA_rd = 7; fwdA_data = 64'hAA;
        fwdB_we = 1; fwdB_rd = 7; fwdB_data = 64'hBB;
        step("fwdA");
        chk("fwdA.abs", alu_rs1, 64'hAA);
        rs1_addr = 0; fwdA_rd = 0; fwdB_rd = 0;
        step("x0");
        chk("x0.abs", alu_rs1, 64'd0);
        fwdA_we = 0; fwdB_rd = 7; rs1_addr = 7;
        step("fwdB");
        chk("fwdB.abs", alu_rs1, 64'hBB);

        // Stall three cycles then stall+flush
        frz1 = alu_rs1; frz2 = alu_rs2;
        stall = 1; rs1_data = 64'h1234;
        fwdB_we = 0; aluop = 3;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall.frz", alu_rs1, frz1);
        end
        flush = 1;
        step("stflush");
        chk("stflush.abs", 64'(out_valid), 64'd0);
        idle();

        // Immediate path ignores bit 30 on I-type
        in_valid = 1; aluop = 2; funct3 = 0;
        is_rtype = 0; funct7_b5 = 1; alu_src = 1;
        imm = -64'sd4; rs2_data = 64'h77; rs2_addr = 3;
        step("imm");
        chk("imm.code_abs", 64'(alu_code), 64'h2);
        chk("imm.op2_abs", alu_rs2, 64'hFFFF_FFFF_FFFF_FFFC);

        // Illegal op then a bubble
        alu_src = 0; funct3 = 1;
        step("ill");
        chk("ill.abs", 64'(illegal_op), 64'd1);
        in_valid = 0;
        step("bubble");
        chk("bubble.abs", 64'(illegal_op), 64'd0);

        // Flush with valid input kills it
        in_valid = 1; funct3 = 7; flush = 1;
        step("flushin");
        flush = 0;
        step("and");

        // Randomized run
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 9) < 8);
            aluop = 2'($urandom);
            is_rtype = 1'($urandom);
            funct3 = 3'($urandom);
            funct7_b5 = 1'($urandom);
            alu_src = 1'($urandom);
            rs1_addr = 5'($urandom_range(0, 3));
            rs2_addr = 5'($urandom_range(0, 3));
            rd_addr = 5'($urandom);
            rs1_data = {$urandom, $urandom};
            rs2_data = {$urandom, $urandom};
            imm = {$urandom, $urandom};
            fwdA_we = 1'($urandom);
            fwdA_rd = 5'($urandom_range(0, 3));
            fwdA_data = {$urandom, $urandom};
            fwdB_we = 1'($urandom);
            fwdB_rd = 5'($urandom_range(0, 3));
            fwdB_data = {$urandom, $urandom};
            stall = ($urandom_range(0, 9) < 2);
            flush = ($urandom_range(0, 9) < 1);
            step("rand");
        end

        // Asynchronous reset between edges
        idle();
        in_valid = 1; aluop = 2; funct3 = 6;
        rs1_addr = 1; rs1_data = 64'h55; rd_addr = 4;
        step("prerst");
        #3;
        rst_n = 0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst_n = 1;
        step("postrst");

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
